// File: rtl/rx_controller_if.sv
// Bundles the line-side strobes, the ack/status outputs and the consumer valid/ready
// handshake of the receive controller.
interface rx_controller_if #(
  parameter int unsigned DATA_W = 8
);
  logic              csrx;
  logic              bit_in;
  logic              bit_valid;
  logic              stop_det;
  logic              data_ack;
  logic              data_nack;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_done;
  logic              frame_err;
  logic              overflow;
  logic [7:0]        rx_bytes;

  // Controller side
  modport slave (
    input  csrx,
    input  bit_in,
    input  bit_valid,
    input  stop_det,
    input  rx_ready,
    output data_ack,
    output data_nack,
    output rx_data,
    output rx_valid,
    output frame_done,
    output frame_err,
    output overflow,
    output rx_bytes
  );

  // Line sampler / consumer side
  modport master (
    output csrx,
    output bit_in,
    output bit_valid,
    output stop_det,
    output rx_ready,
    input  data_ack,
    input  data_nack,
    input  rx_data,
    input  rx_valid,
    input  frame_done,
    input  frame_err,
    input  overflow,
    input  rx_bytes
  );
endinterface

// File: rtl/rx_controller.sv
// Receive controller: deserializes sampled bits into words, parks them in a two-entry
// ping-pong buffer and hands them to the consumer over valid/ready.
module rx_controller #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  rx_controller_if.slave rx
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRecv = 2'd1;
  localparam logic [1:0] StStop = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CntW-1:0]   bcnt_q, bcnt_d;
  logic [1:0]        full_q, full_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic              wsel_q, wsel_d;
  logic              rsel_q, rsel_d;
  logic              ack_q, ack_d;
  logic              nack_q, nack_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [7:0]        bytes_q, bytes_d;
  logic [DATA_W-1:0] word;

  // Shift register contents including the bit on the line this cycle
  always_comb begin
    if (MSB_FIRST) begin
      word = {sr_q[DATA_W-2:0], rx.bit_in};
    end else begin
      word = {rx.bit_in, sr_q[DATA_W-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    full_d  = full_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    ack_d   = 1'b0;
    nack_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ovf_d   = ovf_q;
    bytes_d = bytes_q;

    if (!rx.csrx) begin
      // Disable wins over everything and drops any buffered words
      state_d = StIdle;
      sr_d    = '0;
      bcnt_d  = '0;
      full_d  = 2'b00;
      buf0_d  = '0;
      buf1_d  = '0;
      wsel_d  = 1'b0;
      rsel_d  = 1'b0;
      ovf_d   = 1'b0;
      bytes_d = 8'd0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StRecv;
          bcnt_d  = '0;
          bytes_d = 8'd0;
          ovf_d   = 1'b0;
        end
        StRecv, StStop: begin
          if (full_q[rsel_q] && rx.rx_ready) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
          end
          if (state_q == StRecv) begin
            if (rx.stop_det) begin
              done_d  = 1'b1;
              err_d   = (bcnt_q != '0);
              bcnt_d  = '0;
              state_d = StStop;
            end else if (rx.bit_valid) begin
              sr_d = word;
              if (bcnt_q == LastBit) begin
                bcnt_d = '0;
                // Registered full flag: a same-cycle drain of this buffer still nacks
                if (!full_q[wsel_q]) begin
                  if (wsel_q) begin
                    buf1_d = word;
                  end else begin
                    buf0_d = word;
                  end
                  full_d[wsel_q] = 1'b1;
                  wsel_d         = ~wsel_q;
                  ack_d          = 1'b1;
                  if (bytes_q != 8'hFF) begin
                    bytes_d = bytes_q + 8'd1;
                  end
                end else begin
                  nack_d = 1'b1;
                  ovf_d  = 1'b1;
                end
              end else begin
                bcnt_d = bcnt_q + 1'b1;
              end
            end
          end else if (full_q == 2'b00) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      bcnt_q  <= '0;
      full_q  <= 2'b00;
      buf0_q  <= '0;
      buf1_q  <= '0;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      ack_q   <= 1'b0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      bytes_q <= 8'd0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      full_q  <= full_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      bytes_q <= bytes_d;
    end
  end

  assign rx.data_ack   = ack_q;
  assign rx.data_nack  = nack_q;
  assign rx.frame_done = done_q;
  assign rx.frame_err  = err_q;
  assign rx.overflow   = ovf_q;
  assign rx.rx_bytes   = bytes_q;
  assign rx.rx_valid   = full_q[rsel_q];
  assign rx.rx_data    = rsel_q ? buf1_q : buf0_q;

endmodule
